line_refill_arbiter: RTL and testbench



---
 rtl/line_refill_arbiter.sv | 106 ++++++++++
 tb/tb_line_refill_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/line_refill_arbiter.sv
// rtl/line_refill_arbiter.sv - round-robin icache/dcache line refill controller
module line_refill_arbiter #(
    parameter int LINE_WIDTH  = 512,
    parameter int BEAT_WIDTH  = 32,
    parameter int BEATS       = LINE_WIDTH / BEAT_WIDTH,
    parameter int TAG_WIDTH   = 18,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ic_req,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]   ic_addr,
    input  logic                               dc_req,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]   dc_addr,
    output logic                               mem_req,
    output logic [31:0]                        mem_addr,
    input  logic                               mem_ack,
    input  logic                               mem_rvalid,
    input  logic [BEAT_WIDTH-1:0]              mem_rdata,
    output logic                               fill_valid,
    output logic                               fill_dest,
    output logic [TAG_WIDTH-1:0]               fill_tag,
    output logic [INDEX_WIDTH-1:0]             fill_index,
    output logic [LINE_WIDTH-1:0]              fill_data,
    output logic                               busy
);
    localparam int ADDR_W = TAG_WIDTH + INDEX_WIDTH;
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RECV, FILL} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       beat_cnt;
    logic [ADDR_W-1:0]      line_addr;
    logic                   dest;
    logic                   last_served;
    logic                   mask;
    logic [LINE_WIDTH-1:0]  buffer;

    logic ic_elig, dc_elig, grant, grant_id;

    // The requester just filled gets one IDLE cycle to drop its req.
    always_comb begin
        ic_elig  = ic_req && !(mask && !last_served);
        dc_elig  = dc_req && !(mask && last_served);
        grant    = (state == IDLE) && (ic_elig || dc_elig);
        grant_id = dc_elig && (!ic_elig || !last_served);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (ic_elig || dc_elig) state_nxt = ISSUE;
            ISSUE: if (mem_ack) state_nxt = RECV;
            RECV:  if (mem_rvalid && beat_cnt == LAST_BEAT) state_nxt = FILL;
            FILL:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt    <= '0;
            line_addr   <= '0;
            dest        <= 1'b0;
            last_served <= 1'b1;
            mask        <= 1'b0;
            buffer      <= '0;
        end else begin
            mask <= (state == FILL);
            if (grant) begin
                line_addr   <= grant_id ? dc_addr : ic_addr;
                dest        <= grant_id;
                last_served <= grant_id;
            end
            if (state == ISSUE && mem_ack) begin
                beat_cnt <= '0;
            end
            if (state == RECV && mem_rvalid) begin
                buffer[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
                if (beat_cnt != LAST_BEAT) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    assign mem_req    = (state == ISSUE);
    assign mem_addr   = {line_addr, {(32-ADDR_W){1'b0}}};
    assign fill_valid = (state == FILL);
    assign fill_dest  = dest;
    assign fill_tag   = line_addr[ADDR_W-1 -: TAG_WIDTH];
    assign fill_index = line_addr[INDEX_WIDTH-1:0];
    assign fill_data  = buffer;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_line_refill_arbiter.sv
// tb/tb_line_refill_arbiter.sv - directed self-checking bench for line_refill_arbiter
module tb_line_refill_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, dc_req;
    logic [25:0]  ic_addr, dc_addr;
    logic         mem_req, mem_ack, mem_rvalid;
    logic [31:0]  mem_addr, mem_rdata;
    logic         fill_valid, fill_dest, busy;
    logic [17:0]  fill_tag;
    logic [7:0]   fill_index;
    logic [511:0] fill_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    line_refill_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .dc_req(dc_req), .dc_addr(dc_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_dest(fill_dest), .fill_tag(fill_tag),
        .fill_index(fill_index), .fill_data(fill_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 512'(mem_req), 512'(1));
    endtask

    // Entered on the negedge right after the grant edge; cycle 1 is this cycle.
    task automatic serve(input int ack_delay, input bit gapped, input bit stray,
                         input logic [31:0] base, input int exp_cycles,
                         input logic exp_dest, input string tag);
        int g;
        logic [511:0] line;
        g = cyc;
        for (int k = 0; k < 16; k++) line[32*k +: 32] = base + 32'(k);
        for (int d = 0; d < ack_delay; d++) begin
            mem_ack = 1'b0; mem_rvalid = stray; mem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        mem_ack = 1'b1; mem_rvalid = stray; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rvalid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (gapped) begin
                mem_rvalid = 1'b0;
                @(negedge clk);
            end
            mem_rvalid = 1'b1; mem_rdata = base + 32'(k);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        check({tag, "_fill"}, 512'(fill_valid), 512'(1));
        check({tag, "_latency"}, 512'(cyc - g + 1), 512'(exp_cycles));
        check({tag, "_dest"}, 512'(fill_dest), 512'(exp_dest));
        check({tag, "_data"}, fill_data, line);
        @(negedge clk);
        check({tag, "_pulse"}, 512'(fill_valid), 512'(0));
    endtask

    initial begin
        bit seen;
        reset = 1'b1; ic_req = 0; dc_req = 0; ic_addr = '0; dc_addr = '0;
        mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_mem_req", 512'(mem_req), 512'(0));
        check("rst_mem_addr", 512'(mem_addr), 512'(0));
        check("rst_fill_valid", 512'(fill_valid), 512'(0));
        check("rst_fill_data", fill_data, 512'(0));
        reset = 1'b0;

        // Single dcache miss, minimum latency: 1 ISSUE + 16 RECV + FILL = cycle 18.
        dc_req = 1'b1; dc_addr = 26'h0ABCD12;
        wait_req("t1");
        check("t1_mem_addr", 512'(mem_addr), 512'(32'h2AF3_4480));
        check("t1_tag", 512'(fill_tag), 512'(18'h0ABCD));
        check("t1_index", 512'(fill_index), 512'(8'h12));
        serve(0, 0, 0, 32'h1000_0000, 18, 1'b1, "t1");
        dc_req = 1'b0;
        @(negedge clk); @(negedge clk);
        check("t1_idle", 512'(busy), 512'(0));

        // Tie after reset, then round-robin under continuous load.
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        ic_addr = 26'h1000001; dc_addr = 26'h2000002;
        ic_req = 1'b1; dc_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                wait_req("rr0");
            end else begin
                check($sformatf("rr%0d_gap_idle", i), 512'(mem_req), 512'(0));
                @(negedge clk);
                check($sformatf("rr%0d_gap_req", i), 512'(mem_req), 512'(1));
            end
            check($sformatf("rr%0d_addr", i), 512'(mem_addr),
                  (i % 2 == 0) ? 512'(32'h4000_0040) : 512'(32'h8000_0080));
            serve(0, 0, 0, 32'h2000_0000 + 32'(i << 8), 18, 1'(i % 2), $sformatf("rr%0d", i));
        end
        ic_req = 1'b0; dc_req = 1'b0;
        @(negedge clk); @(negedge clk);

        // Stalls: 5 extra ISSUE cycles, gap before every beat: 6 + 32 + FILL = cycle 39.
        dc_req = 1'b1; dc_addr = 26'h0000155;
        wait_req("st");
        serve(5, 1, 1, 32'hA000_0000, 39, 1'b1, "st");
        dc_req = 1'b0;
        @(negedge clk); @(negedge clk);

        // Reset mid-RECV after 7 beats.
        dc_req = 1'b1; dc_addr = 26'h3FFFFFF;
        wait_req("rs");
        mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
        for (int k = 0; k < 7; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h7700_0000 + 32'(k);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rs_busy", 512'(busy), 512'(0));
        check("rs_mem_req", 512'(mem_req), 512'(0));
        check("rs_fill_valid", 512'(fill_valid), 512'(0));
        check("rs_fill_tag", 512'(fill_tag), 512'(0));
        check("rs_fill_dest", 512'(fill_dest), 512'(0));
        check("rs_fill_data", fill_data, 512'(0));
        dc_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (fill_valid) seen = 1'b1;
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (fill_valid) seen = 1'b1;
        end
        check("rs_no_fill", 512'(seen), 512'(0));
        dc_req = 1'b1; dc_addr = 26'h0000040;
        wait_req("rs2");
        serve(0, 0, 0, 32'h5500_0000, 18, 1'b1, "rs2");
        dc_req = 1'b0;
        @(negedge clk); @(negedge clk);

        // Early drop: ic_req released right after grant, fill still delivered.
        ic_req = 1'b1; ic_addr = 26'h0123456;
        wait_req("ed");
        ic_req = 1'b0;
        serve(0, 0, 0, 32'hC000_0000, 18, 1'b0, "ed");
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy || mem_req) seen = 1'b1;
        end
        check("ed_no_regrant", 512'(seen), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
